// File: rtl/fusion_accum_2b.sv
// rtl/fusion_accum_2b.sv - precision-fused brick-product frame accumulator with result handshake
module fusion_accum_2b (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  Precision,
    input  logic [79:0] P_in,
    input  logic        in_valid,
    input  logic        in_first,
    input  logic        in_last,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Psum_out,
    output logic        prec_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10,
        HOLD  = 2'b11
    } state_t;

    state_t      state;
    logic [3:0]  prec_q;
    logic        s1_valid;
    logic        s1_first;
    logic        s1_last;
    logic [31:0] s1_sum;
    logic [31:0] acc;

    logic        accept;
    logic        take_beat;
    logic        take_first;
    logic [1:0]  raw_i;
    logic [1:0]  raw_w;
    logic [3:0]  prec_clean;
    logic        prec_bad;
    logic [3:0]  prec_use;
    logic [1:0]  i_mask;
    logic [1:0]  w_mask;
    logic [3:0]  kk;
    logic [1:0]  i_idx;
    logic [1:0]  w_idx;
    logic [3:0]  shift;
    logic [20:0] term;
    logic [20:0] beat_sum;
    logic [31:0] beat_sum_ext;

    // Handshake qualification and precision code cleanup (illegal 11 fields fall back to 2b)
    always_comb begin
        accept     = in_valid && in_ready;
        take_first = accept && in_first;
        // Non-first beats only count once a frame is open; stray beats in IDLE are dropped
        take_beat  = accept && (in_first || (state == RUN));
        raw_i      = Precision[3:2];
        raw_w      = Precision[1:0];
        prec_bad   = (raw_i == 2'b11) || (raw_w == 2'b11);
        prec_clean = {(raw_i == 2'b11) ? 2'b00 : raw_i,
                      (raw_w == 2'b11) ? 2'b00 : raw_w};
        // The first beat of a frame uses the code it carries; later beats use the latched one
        prec_use   = in_first ? prec_clean : prec_q;
    end

    // Beat sum: each brick product is weighted by 4^(input slice + weight slice)
    always_comb begin
        // Slice index masks: code 00 -> 1 slice, 01 -> 2 slices, 10 -> 4 slices
        i_mask   = {prec_use[3], prec_use[3] | prec_use[2]};
        w_mask   = {prec_use[1], prec_use[1] | prec_use[0]};
        kk       = 4'd0;
        i_idx    = 2'd0;
        w_idx    = 2'd0;
        shift    = 4'd0;
        term     = 21'd0;
        beat_sum = 21'd0;
        for (int k = 0; k < 16; k++) begin
            kk       = 4'(k);
            i_idx    = kk[3:2] & i_mask;
            w_idx    = kk[1:0] & w_mask;
            shift    = {1'b0, i_idx, 1'b0} + {1'b0, w_idx, 1'b0};
            term     = {{16{P_in[5*k+4]}}, P_in[5*k +: 5]};
            term     = term << shift;
            beat_sum = beat_sum + term;
        end
        beat_sum_ext = {{11{beat_sum[20]}}, beat_sum};
    end

    // Frame precision latch and sticky illegal-code flag, both sampled only on a frame start
    always_ff @(posedge clk) begin
        if (rst) begin
            prec_q   <= 4'b0000;
            prec_err <= 1'b0;
        end else if (take_first) begin
            prec_q <= prec_clean;
            if (prec_bad) begin
                prec_err <= 1'b1;
            end
        end
    end

    // Stage S1: capture the beat sum and its frame markers on acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_sum   <= 32'd0;
        end else begin
            s1_valid <= take_beat;
            if (take_beat) begin
                s1_sum   <= beat_sum_ext;
                s1_first <= in_first;
                s1_last  <= in_last;
            end
        end
    end

    // Stage S2: a first beat reloads the accumulator, later beats add with 32-bit wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= 32'd0;
        end else if (s1_valid) begin
            acc <= s1_first ? s1_sum : (acc + s1_sum);
        end
    end

    // Frame control FSM with registered in_ready, out_valid and Psum_out
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            Psum_out  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_first) begin
                        if (in_last) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    // A new first beat simply restarts the frame; S2 reloads acc from it
                    if (accept && in_last) begin
                        state    <= DRAIN;
                        in_ready <= 1'b0;
                    end
                end
                DRAIN: begin
                    // S2 folds the last beat into acc on this same edge
                    if (s1_valid && s1_last) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    // First HOLD cycle publishes acc; the result then stays until taken
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        Psum_out  <= acc;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        Psum_out  <= 32'd0;
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fusion_accum_2b.sv
// tb/tb_fusion_accum_2b.sv - randomized and directed self-checking bench for fusion_accum_2b
module tb_fusion_accum_2b;

    logic        clk;
    logic        rst;
    logic [3:0]  Precision;
    logic [79:0] P_in;
    logic        in_valid;
    logic        in_first;
    logic        in_last;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Psum_out;
    logic        prec_err;

    int n_assert;
    int n_fail;
    logic err_m;

    fusion_accum_2b dut (
        .clk       (clk),
        .rst       (rst),
        .Precision (Precision),
        .P_in      (P_in),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Psum_out  (Psum_out),
        .prec_err  (prec_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int code_n(input logic [1:0] c);
        return (c == 2'b11) ? 1 : (1 << int'(c));
    endfunction

    function automatic logic [31:0] beat_val(input logic [79:0] p, input logic [3:0] prec);
        int ni, nw, s;
        logic signed [4:0] v;
        ni = code_n(prec[3:2]);
        nw = code_n(prec[1:0]);
        s  = 0;
        for (int k = 0; k < 16; k++) begin
            v = p[5*k +: 5];
            s += int'(v) * (4 ** (((k / 4) % ni) + ((k % 4) % nw)));
        end
        return 32'(s);
    endfunction

    function automatic logic [79:0] gen_p(input int mode);
        logic [95:0] r;
        logic [79:0] p;
        if (mode == 0) begin
            for (int k = 0; k < 16; k++) p[5*k +: 5] = 5'b00001;
        end else if (mode == 1) begin
            for (int k = 0; k < 16; k++) p[5*k +: 5] = 5'b11111;
        end else begin
            r = {$urandom(), $urandom(), $urandom()};
            p = r[79:0];
        end
        return p;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        err_m = 1'b0;
    endtask

    task automatic send_beat(input logic [79:0] p, input logic [3:0] prec, input logic f, input logic l);
        chk("in_ready_before_beat", {31'd0, in_ready}, 32'd1);
        P_in      = p;
        Precision = prec;
        in_first  = f;
        in_last   = l;
        in_valid  = 1'b1;
        if (f && ((prec[3:2] == 2'b11) || (prec[1:0] == 2'b11))) err_m = 1'b1;
        tick();
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_last   = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int n, input logic [3:0] prec0,
                             input logic [3:0] prec_other, input int mode, input int hold);
        logic [31:0] exp;
        logic [79:0] p;
        exp = 32'd0;
        for (int b = 0; b < n; b++) begin
            p = gen_p(mode);
            exp = exp + beat_val(p, prec0);
            send_beat(p, (b == 0) ? prec0 : prec_other, b == 0, b == n - 1);
        end
        chk({tag, "_ov_t0"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_rdy_t0"}, {31'd0, in_ready}, 32'd0);
        tick();
        chk({tag, "_ov_t1"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_psum_t1"}, Psum_out, 32'd0);
        tick();
        chk({tag, "_ov_t2"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_psum"}, Psum_out, exp);
        chk({tag, "_err"}, {31'd0, prec_err}, {31'd0, err_m});
        for (int h = 0; h < hold; h++) begin
            tick();
            chk({tag, "_hold_ov"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "_hold_psum"}, Psum_out, exp);
            chk({tag, "_hold_rdy"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_done_ov"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_done_rdy"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_done_psum"}, Psum_out, 32'd0);
    endtask

    initial begin
        int n;
        logic [3:0] pa;
        logic [3:0] pb;
        n_assert  = 0;
        n_fail    = 0;
        err_m     = 1'b0;
        rst       = 1'b0;
        Precision = 4'b0000;
        P_in      = 80'd0;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        do_reset();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_psum", Psum_out, 32'd0);
        chk("rst_prec_err", {31'd0, prec_err}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        run_frame("p0000_one", 1, 4'b0000, 4'b0000, 0, 0);
        run_frame("p1010_one", 1, 4'b1010, 4'b1010, 0, 1);
        run_frame("p0101_one", 1, 4'b0101, 4'b0101, 0, 0);
        run_frame("p0101_switch", 2, 4'b0101, 4'b0000, 0, 0);
        run_frame("neg_hold5", 3, 4'b0000, 4'b0000, 1, 5);

        run_frame("p1100_illegal", 1, 4'b1100, 4'b1100, 0, 0);
        run_frame("after_illegal", 2, 4'b1001, 4'b0110, 2, 1);
        chk("err_sticky", {31'd0, prec_err}, 32'd1);
        do_reset();
        chk("err_cleared", {31'd0, prec_err}, 32'd0);

        // Abandon a frame mid-stream
        send_beat(gen_p(2), 4'b1010, 1'b1, 1'b0);
        send_beat(gen_p(2), 4'b1010, 1'b0, 1'b0);
        do_reset();
        for (int c = 0; c < 3; c++) begin
            chk("abandon_ov", {31'd0, out_valid}, 32'd0);
            chk("abandon_rdy", {31'd0, in_ready}, 32'd1);
            tick();
        end
        run_frame("after_abandon", 1, 4'b0000, 4'b0000, 0, 0);

        // Reset during HOLD drops the pending result
        send_beat(gen_p(2), 4'b0110, 1'b1, 1'b1);
        tick();
        tick();
        chk("hold_before_rst_ov", {31'd0, out_valid}, 32'd1);
        do_reset();
        chk("hold_rst_ov", {31'd0, out_valid}, 32'd0);
        chk("hold_rst_psum", Psum_out, 32'd0);
        chk("hold_rst_rdy", {31'd0, in_ready}, 32'd1);

        // A beat without in_first while idle is dropped
        send_beat(gen_p(0), 4'b0000, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            chk("stray_ov", {31'd0, out_valid}, 32'd0);
            chk("stray_rdy", {31'd0, in_ready}, 32'd1);
            tick();
        end
        run_frame("after_stray", 2, 4'b0010, 4'b1000, 2, 0);

        // In-frame restart: the second first-beat discards the partial frame
        send_beat(gen_p(2), 4'b1010, 1'b1, 1'b0);
        send_beat(gen_p(2), 4'b1010, 1'b0, 1'b0);
        run_frame("restart", 2, 4'b0100, 4'b1111, 2, 0);

        for (int f = 0; f < 25; f++) begin
            n  = int'($urandom_range(1, 4));
            pa = 4'($urandom_range(0, 15));
            pb = 4'($urandom_range(0, 15));
            run_frame("rand", n, pa, pb, 2, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fusion_accum_2b.md
FUSION_ACCUM_2B -- requirements
Module: fusion_accum_2b

Interface
REQ-001 The module SHALL have one clock and a synchronous active-high reset, with ports named clk and rst.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 Precision  in  4  operand precision code: [3:2] input code, [1:0] weight code; 00=2b, 01=4b, 10=8b, 11=illegal.
REQ-005 P_in  in  80  sixteen signed 5-bit brick products; brick k occupies P_in[5k+:5].
REQ-006 in_valid  in  1  marks the beat on P_in as valid.
REQ-007 in_first  in  1  marks the first beat of a frame.
REQ-008 in_last  in  1  marks the last beat of a frame.
REQ-009 in_ready  out  1  signals that the block can accept a beat.
REQ-010 out_valid  out  1  signals that Psum_out holds a completed frame result.
REQ-011 out_ready  in  1  signals that the consumer takes the result.
REQ-012 Psum_out  out  32  signed accumulated frame result.
REQ-013 prec_err  out  1  sticky flag for an illegal precision code.

Function
REQ-014 A beat SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-015 Precision SHALL be sampled only on an accepted beat with in_first=1 and held for the whole frame; later changes SHALL be ignored until the next frame.
REQ-016 Any code field equal to 11 SHALL be treated as 00, and prec_err SHALL be set to 1 and held until rst.
REQ-017 Slice counts per frame: nI=2^input_code and nW=2^weight_code.
REQ-018 For each brick: i_idx=(k>>2) mod nI, w_idx=(k mod 4) mod nW, shift_k=2*(i_idx+w_idx).
REQ-019 Beat sum SHALL be Σ_k sign_extend(P[k])<<shift_k, computed at full 21-bit precision and sign-extended to 32 bits.
REQ-020 Stage S1 SHALL register the beat sum and the beat's first/last flags on acceptance.
REQ-021 Stage S2, one edge later: if the S1 beat was first, acc SHALL load the beat sum; otherwise acc SHALL become acc plus the beat sum.
REQ-022 Accumulation SHALL wrap modulo 2^32 in two's complement, without saturation.
REQ-023 FSM states SHALL be IDLE, RUN, DRAIN and HOLD.
REQ-024 IDLE: in_ready=1; an accepted beat with in_first=1 SHALL go to RUN, or to DRAIN if in_last=1; an accepted beat without in_first SHALL be discarded.
REQ-025 RUN: in_ready=1; an accepted beat with in_last=1 SHALL go to DRAIN.
REQ-026 RUN: an accepted beat with in_first=1 SHALL restart the frame, discarding the prior accumulation and re-latching Precision.
REQ-027 DRAIN: in_ready=0; state SHALL go to HOLD on the next edge, once S2 has absorbed the last beat.
REQ-028 HOLD: out_valid=1, in_ready=0, and Psum_out=acc held stable; out_ready=1 SHALL return the state to IDLE on that edge.
REQ-029 Latency: an in_last beat accepted at edge t SHALL raise out_valid after edge t+2.
REQ-030 out_valid SHALL stay high until the out_ready handshake completes, with no timeout.
REQ-031 Psum_out SHALL be 0 whenever out_valid=0.

Reset
REQ-032 On rst=1 at a rising edge, the state SHALL become IDLE and acc, S1, Psum_out, out_valid and prec_err SHALL become 0, with latched Precision cleared to 0000.
REQ-033 After reset release, in_ready SHALL be 1.
REQ-034 rst SHALL take priority over all other inputs.
REQ-035 A rst mid-frame or during HOLD SHALL abandon the frame with no out_valid pulse.

Verification
REQ-036 Precision=0000, all P=+1, one beat with first&last at edge t -> out_valid after edge t+2, Psum_out=16.
REQ-037 Precision=1010, all P=+1, single beat -> Psum_out=(1+4+16+64)^2=7225.
REQ-038 Precision=0101, all P=+1, single beat -> Psum_out=100; Precision switched to 0000 mid-frame on a second beat -> result uses 0101 for both beats, 200.
REQ-039 Precision=0000, three beats all P=-1 (0x1F), out_ready held low 5 cycles -> Psum_out=-48 (0xFFFFFFD0) stable, out_valid=1 and in_ready=0 throughout; one cycle of out_ready -> IDLE with in_ready=1.
REQ-040 Precision=1100, all P=+1, single beat -> prec_err=1, Psum_out=16; prec_err stays 1 over later legal frames until rst.
REQ-041 rst asserted after 2 of 4 beats -> no out_valid; a new single-beat frame of all P=+1 at 0000 -> 16, with no residue from the old frame.
